// File: rtl/multdiv_defs.sv
// Shared definitions for the iterative multiply/divide unit:
// FSM state encodings, iteration/latency constants and operand helpers.
package multdiv_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  localparam int MD_ITER    = 32;
  localparam int MD_LATENCY = 33;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Two's complement magnitude; |INT_MIN| stays 0x80000000 as unsigned.
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/cla_full_adder.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Ports: a, b, cin in; sum, cout out.
module cla_full_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin
    logic [31:0] g;
    logic [31:0] p;
    logic [3:0]  gg;
    logic [3:0]  pp;
    logic [3:0]  c;
    logic        cy;
    g   = a & b;
    p   = a ^ b;
    cy  = cin;
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      gg   = g[4*k +: 4];
      pp   = p[4*k +: 4];
      c[0] = cy;
      c[1] = gg[0] | (pp[0] & cy);
      c[2] = gg[1] | (pp[1] & gg[0])
           | (pp[1] & pp[0] & cy);
      c[3] = gg[2] | (pp[2] & gg[1])
           | (pp[2] & pp[1] & gg[0])
           | (pp[2] & pp[1] & pp[0] & cy);
      sum[4*k +: 4] = pp ^ c;
      cy = gg[3] | (pp[3] & gg[2])
         | (pp[3] & pp[2] & gg[1])
         | (pp[3] & pp[2] & pp[1] & gg[0])
         | ((&pp) & cy);
    end
    cout = cy;
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide, 33-cycle fixed latency.
// Ports: clock, reset (sync, active-high); data_operandA/B, ctrl_MULT/DIV in;
// data_result, data_exception, data_resultRDY, busy out (all registered).
import multdiv_defs::*;

module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  md_state_t   state;
  md_state_t   state_next;
  logic        start;
  logic        iter;
  logic        last;
  logic        is_div;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [31:0] opnd;
  logic        sa;
  logic        sb;
  logic        bzero;
  logic        neg;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_sum;
  logic        add_co;
  logic        take;
  logic [31:0] neg_in;
  logic [31:0] neg_sum;
  logic        neg_co;
  logic [31:0] sp_lo;
  logic [31:0] sp_hi;
  logic [31:0] res_fix;
  logic        exc_fix;

  assign start  = ctrl_MULT | ctrl_DIV;
  assign is_div = (state == ST_DIV);
  assign iter   = (state == ST_MUL) | is_div;
  assign last   = (cnt == 5'(MD_ITER - 1));
  assign neg    = sa ^ sb;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ctrl_MULT ? ST_MUL : ST_DIV;
    end else begin
      unique case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_MUL,
        ST_DIV:  state_next = last ? ST_DONE : state;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state != ST_IDLE);
    data_resultRDY = (state == ST_DONE);
  end

  // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}.
  // The divide path shifts in one dividend bit; acc[63] is the 33rd trial bit.
  always_comb begin
    add_a  = is_div ? {acc[62:32], acc[31]} : acc[63:32];
    add_b  = is_div ? ~opnd : opnd;
    add_ci = is_div;
  end

  cla_full_adder u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .sum  (add_sum),
    .cout (add_co)
  );

  always_comb begin
    take     = 1'b0;
    acc_next = acc;
    if (is_div) begin
      take     = acc[63] | add_co;
      acc_next = {take ? add_sum : add_a, acc[30:0], take};
    end else if (acc[0]) begin
      acc_next = {add_co, add_sum, acc[31:1]};
    end else begin
      acc_next = {1'b0, acc[63:1]};
    end
  end

  assign neg_in = ~acc_next[31:0];

  cla_full_adder u_neg (
    .a    (neg_in),
    .b    (32'd0),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (neg_co)
  );

  // The low-word negation carries into the high word only when low is zero.
  always_comb begin
    sp_lo = neg ? neg_sum : acc_next[31:0];
    sp_hi = neg ? (~acc_next[63:32] + {31'd0, neg_co})
                : acc_next[63:32];
    if (is_div) begin
      res_fix = bzero ? 32'd0 : sp_lo;
      exc_fix = bzero | (acc_next[31] & ~neg);
    end else begin
      res_fix = sp_lo;
      exc_fix = (sp_hi != {32{sp_lo[31]}});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc            <= '0;
      opnd           <= '0;
      cnt            <= '0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      bzero          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      sa    <= data_operandA[31];
      sb    <= data_operandB[31];
      bzero <= (data_operandB == 32'd0);
      if (ctrl_MULT) begin
        acc  <= {32'd0, mag(data_operandB)};
        opnd <= mag(data_operandA);
      end else begin
        acc  <= {32'd0, mag(data_operandA)};
        opnd <= mag(data_operandB);
      end
    end else if (iter) begin
      acc <= acc_next;
      cnt <= cnt + 5'd1;
      if (last) begin
        data_result    <= res_fix;
        data_exception <= exc_fix;
      end
    end
  end

endmodule
